hazard_ctrl: RTL and testbench

Pipeline hazard controller for the five-stage riscky core. Watches register addresses and control bits in decode, execute, memory and writeback, then drives the stall, flush and forwarding controls of the stage registers. It sequences a memory-wait state machine with a timeout watchdog, so the pipeline freezes cleanly while data memory is busy. Sits beside the datapath and drives every pipeline register's enable/clear.

---
 rtl/hazard_ctrl.sv | 176 +++++++++++++++++
 tb/tb_hazard_ctrl.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: stall/flush/forward control for the five-stage riscky pipeline.
// Handles RAW forwarding, load-use bubbles, branch squash, and a data-memory
// wait FSM with a timeout watchdog.
// Optional build macro HAZARD_PERF_CNT_EN adds the stall/flush perf counters;
// without it the counter ports are tied to zero.
module hazard_ctrl #(
    parameter int REG_ADDR_W  = 5,
    parameter int MEM_TIMEOUT = 255,
    parameter int CNT_W       = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [REG_ADDR_W-1:0] rs1_d,
    input  logic [REG_ADDR_W-1:0] rs2_d,
    input  logic [REG_ADDR_W-1:0] rs1_e,
    input  logic [REG_ADDR_W-1:0] rs2_e,
    input  logic [REG_ADDR_W-1:0] rd_e,
    input  logic                  result_src_e0,
    input  logic                  pc_src_e,
    input  logic [REG_ADDR_W-1:0] rd_m,
    input  logic [REG_ADDR_W-1:0] rd_w,
    input  logic                  reg_write_m,
    input  logic                  reg_write_w,
    input  logic                  mem_req_m,
    input  logic                  mem_ready_m,
    output logic [1:0]            forward_a_e,
    output logic [1:0]            forward_b_e,
    output logic                  stall_f,
    output logic                  stall_d,
    output logic                  stall_e,
    output logic                  stall_m,
    output logic                  flush_d,
    output logic                  flush_e,
    output logic                  flush_w,
    output logic                  mem_timeout,
    output logic [CNT_W-1:0]      stall_cycles,
    output logic [CNT_W-1:0]      flush_count
);

    localparam logic [0:0] S_RUN  = 1'b0;
    localparam logic [0:0] S_WAIT = 1'b1;

    // Wide enough to hold MEM_TIMEOUT itself; the counter never exceeds it.
    localparam int WCNT_W = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);

    localparam logic [WCNT_W-1:0] WCNT_MAX = WCNT_W'(MEM_TIMEOUT);
    localparam logic [WCNT_W-1:0] WCNT_ONE = WCNT_W'(1);

    logic [0:0]        state_q, state_d;
    logic [WCNT_W-1:0] wcnt_q, wcnt_d;

    logic lw_stall;
    logic mem_start;
    logic wait_hold;
    logic freeze;
    logic timeout_hit;

    // Operand source select: memory-stage result is younger, so it wins.
    function automatic logic [1:0] fwd_sel(input logic [REG_ADDR_W-1:0] rs);
        if (reg_write_m && (rd_m != '0) && (rd_m == rs))
            return 2'b10;
        else if (reg_write_w && (rd_w != '0) && (rd_w == rs))
            return 2'b01;
        else
            return 2'b00;
    endfunction

    assign lw_stall    = result_src_e0 && (rd_e != '0) &&
                         ((rd_e == rs1_d) || (rd_e == rs2_d));
    // The cycle that discovers a busy memory already freezes the pipe.
    assign mem_start   = (state_q == S_RUN)  && mem_req_m && !mem_ready_m;
    assign wait_hold   = (state_q == S_WAIT) && !mem_ready_m;
    assign freeze      = mem_start || wait_hold;
    assign timeout_hit = wait_hold && (wcnt_q == WCNT_MAX);

    // Memory-wait FSM next state and watchdog count.
    always_comb begin
        state_d = state_q;
        wcnt_d  = wcnt_q;
        case (state_q)
            S_RUN: begin
                if (mem_start) begin
                    state_d = S_WAIT;
                    wcnt_d  = WCNT_ONE;
                end
            end
            S_WAIT: begin
                if (mem_ready_m || timeout_hit) begin
                    // Timeout abandons the access as if it had completed.
                    state_d = S_RUN;
                    wcnt_d  = '0;
                end else begin
                    wcnt_d  = wcnt_q + WCNT_ONE;
                end
            end
            default: begin
                state_d = S_RUN;
                wcnt_d  = '0;
            end
        endcase
    end

    // FSM state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_RUN;
            wcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            wcnt_q  <= wcnt_d;
        end
    end

    // Stage controls; priority is memory freeze > branch flush > load-use.
    // Reset is folded in so the stage registers see bubbles immediately.
    always_comb begin
        forward_a_e = 2'b00;
        forward_b_e = 2'b00;
        stall_f     = 1'b0;
        stall_d     = 1'b0;
        stall_e     = 1'b0;
        stall_m     = 1'b0;
        flush_d     = 1'b0;
        flush_e     = 1'b0;
        flush_w     = 1'b0;
        mem_timeout = 1'b0;
        if (!rst_n) begin
            flush_d = 1'b1;
            flush_e = 1'b1;
            flush_w = 1'b1;
        end else begin
            forward_a_e = fwd_sel(rs1_e);
            forward_b_e = fwd_sel(rs2_e);
            mem_timeout = timeout_hit;
            if (freeze) begin
                stall_f = 1'b1;
                stall_d = 1'b1;
                stall_e = 1'b1;
                stall_m = 1'b1;
                flush_w = 1'b1;
            end else if (pc_src_e) begin
                flush_d = 1'b1;
                flush_e = 1'b1;
            end else if (lw_stall) begin
                stall_f = 1'b1;
                stall_d = 1'b1;
                flush_e = 1'b1;
            end
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    logic [CNT_W-1:0] stall_cycles_q;
    logic [CNT_W-1:0] flush_count_q;

    // Perf counters; free-running and wrap naturally at 2^CNT_W.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cycles_q <= '0;
            flush_count_q  <= '0;
        end else begin
            if (stall_f || stall_d || stall_e || stall_m)
                stall_cycles_q <= stall_cycles_q + CNT_W'(1);
            if (flush_d || flush_e)
                flush_count_q <= flush_count_q + CNT_W'(1);
        end
    end

    assign stall_cycles = stall_cycles_q;
    assign flush_count  = flush_count_q;
`else
    assign stall_cycles = '0;
    assign flush_count  = '0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: stimulus pushes hand-computed expected
// outputs, a negedge monitor pops and compares them (and the perf counters).
module tb_hazard_ctrl;

    localparam int AW    = 5;
    localparam int CNT_W = 32;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [AW-1:0] rs1_d, rs2_d, rs1_e, rs2_e, rd_e, rd_m, rd_w;
    logic          result_src_e0, pc_src_e, reg_write_m, reg_write_w;
    logic          mem_req_m, mem_ready_m;
    logic [1:0]    forward_a_e, forward_b_e;
    logic          stall_f, stall_d, stall_e, stall_m;
    logic          flush_d, flush_e, flush_w, mem_timeout;
    logic [CNT_W-1:0] stall_cycles, flush_count;

    hazard_ctrl #(.REG_ADDR_W(AW), .MEM_TIMEOUT(4), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .rs1_d(rs1_d), .rs2_d(rs2_d), .rs1_e(rs1_e), .rs2_e(rs2_e), .rd_e(rd_e),
        .result_src_e0(result_src_e0), .pc_src_e(pc_src_e),
        .rd_m(rd_m), .rd_w(rd_w), .reg_write_m(reg_write_m), .reg_write_w(reg_write_w),
        .mem_req_m(mem_req_m), .mem_ready_m(mem_ready_m),
        .forward_a_e(forward_a_e), .forward_b_e(forward_b_e),
        .stall_f(stall_f), .stall_d(stall_d), .stall_e(stall_e), .stall_m(stall_m),
        .flush_d(flush_d), .flush_e(flush_e), .flush_w(flush_w),
        .mem_timeout(mem_timeout),
        .stall_cycles(stall_cycles), .flush_count(flush_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [11:0] o;
        bit          rst;
        string       nm;
    } item_t;

    item_t sb[$];
    int    checks = 0;
    int    fails  = 0;
    int    acc_s  = 0;
    int    acc_f  = 0;
    logic [11:0] act;

    // Monitor: one expected item per cycle, checked on the falling edge.
    always @(negedge clk) begin
        if (sb.size() > 0) begin
            item_t it;
            it  = sb.pop_front();
            act = {forward_a_e, forward_b_e, stall_f, stall_d, stall_e, stall_m,
                   flush_d, flush_e, flush_w, mem_timeout};
            checks++;
            if (act !== it.o) begin
                fails++;
                $display("FAIL %s: got fa=%b fb=%b st=%b fl=%b tmo=%b, want fa=%b fb=%b st=%b fl=%b tmo=%b",
                         it.nm, act[11:10], act[9:8], act[7:4], act[3:1], act[0],
                         it.o[11:10], it.o[9:8], it.o[7:4], it.o[3:1], it.o[0]);
            end
            if (it.rst) begin
                acc_s = 0;
                acc_f = 0;
            end
            checks++;
            if (stall_cycles !== CNT_W'(acc_s) || flush_count !== CNT_W'(acc_f)) begin
                fails++;
                $display("FAIL %s_cnt: got stall_cycles=%0d flush_count=%0d, want %0d %0d",
                         it.nm, stall_cycles, flush_count, acc_s, acc_f);
            end
`ifdef HAZARD_PERF_CNT_EN
            if (!it.rst) begin
                if (|it.o[7:4])         acc_s = acc_s + 1;
                if (it.o[3] || it.o[2]) acc_f = acc_f + 1;
            end
`endif
        end
    end

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in();
        rst_n = 1'b1;
        rs1_d = '0; rs2_d = '0; rs1_e = '0; rs2_e = '0;
        rd_e = '0; rd_m = '0; rd_w = '0;
        result_src_e0 = 1'b0; pc_src_e = 1'b0;
        reg_write_m = 1'b0; reg_write_w = 1'b0;
        mem_req_m = 1'b0; mem_ready_m = 1'b0;
    endtask

    // Expected outputs: st = {f,d,e,m}, fl = {d,e,w}.
    task automatic push(input logic [1:0] fa, input logic [1:0] fb,
                        input logic [3:0] st, input logic [2:0] fl,
                        input logic tmo, input string nm);
        item_t it;
        it.o   = {fa, fb, st, fl, tmo};
        it.rst = !rst_n;
        it.nm  = nm;
        sb.push_back(it);
    endtask

    initial begin
        idle_in();
        rst_n = 1'b0;

        // Reset: bubbles everywhere, forwarding suppressed.
        nxt(); rst_n = 1'b0; rs1_e = 5; rd_m = 5; reg_write_m = 1;
        push(2'b00, 2'b00, 4'b0000, 3'b111, 1'b0, "reset");
        nxt(); idle_in();
        push(2'b00, 2'b00, 4'b0000, 3'b000, 1'b0, "idle");

        // Forwarding.
        nxt(); rs1_e = 5; rd_m = 5; rd_w = 5; reg_write_m = 1; reg_write_w = 1;
        push(2'b10, 2'b00, 4'b0000, 3'b000, 1'b0, "fwd_mem_wins");
        nxt(); rs1_e = 0; rd_m = 0; rd_w = 5;
        push(2'b00, 2'b00, 4'b0000, 3'b000, 1'b0, "fwd_x0");
        nxt(); rs1_e = 5; rs2_e = 5; rd_m = 5; reg_write_m = 0; rd_w = 5; reg_write_w = 1;
        push(2'b01, 2'b01, 4'b0000, 3'b000, 1'b0, "fwd_wb");
        nxt(); rs1_e = 3; rs2_e = 9; rd_m = 9; reg_write_m = 1; rd_w = 3;
        push(2'b01, 2'b10, 4'b0000, 3'b000, 1'b0, "fwd_mixed");

        // Load-use: one bubble, then normal flow.
        nxt(); idle_in(); result_src_e0 = 1; rd_e = 7; rs2_d = 7;
        push(2'b00, 2'b00, 4'b1100, 3'b010, 1'b0, "load_use");
        nxt(); result_src_e0 = 0;
        push(2'b00, 2'b00, 4'b0000, 3'b000, 1'b0, "load_use_done");
        nxt(); result_src_e0 = 1; rd_e = 0; rs1_d = 0; rs2_d = 0;
        push(2'b00, 2'b00, 4'b0000, 3'b000, 1'b0, "load_x0");

        // Branch, and branch winning over load-use.
        nxt(); idle_in(); pc_src_e = 1;
        push(2'b00, 2'b00, 4'b0000, 3'b110, 1'b0, "branch");
        nxt(); result_src_e0 = 1; rd_e = 7; rs1_d = 7;
        push(2'b00, 2'b00, 4'b0000, 3'b110, 1'b0, "branch_over_lu");

        // Memory wait of 3 cycles with pending branch/load-use and forwarding.
        nxt(); rs1_e = 5; rd_m = 5; reg_write_m = 1; mem_req_m = 1; mem_ready_m = 0;
        push(2'b10, 2'b00, 4'b1111, 3'b001, 1'b0, "mw1");
        nxt();
        push(2'b10, 2'b00, 4'b1111, 3'b001, 1'b0, "mw2");
        nxt();
        push(2'b10, 2'b00, 4'b1111, 3'b001, 1'b0, "mw3");
        nxt(); mem_ready_m = 1;
        push(2'b10, 2'b00, 4'b0000, 3'b110, 1'b0, "mw_release");
        nxt(); idle_in();
        push(2'b00, 2'b00, 4'b0000, 3'b000, 1'b0, "mw_after");

        // Ready on the first request cycle: no freeze, FSM stays in RUN.
        nxt(); mem_req_m = 1; mem_ready_m = 1;
        push(2'b00, 2'b00, 4'b0000, 3'b000, 1'b0, "mem_ready_now");
        nxt(); mem_req_m = 0; mem_ready_m = 0;
        push(2'b00, 2'b00, 4'b0000, 3'b000, 1'b0, "mem_zero_after");

        // Watchdog with MEM_TIMEOUT=4.
        nxt(); mem_req_m = 1; mem_ready_m = 0;
        push(2'b00, 2'b00, 4'b1111, 3'b001, 1'b0, "to_enter");
        for (int i = 1; i <= 3; i++) begin
            nxt();
            push(2'b00, 2'b00, 4'b1111, 3'b001, 1'b0, $sformatf("to_w%0d", i));
        end
        nxt();
        push(2'b00, 2'b00, 4'b1111, 3'b001, 1'b1, "to_fire");
        nxt(); mem_req_m = 0;
        push(2'b00, 2'b00, 4'b0000, 3'b000, 1'b0, "to_back_run");

        // Reset in the middle of a wait.
        nxt(); mem_req_m = 1; mem_ready_m = 0;
        push(2'b00, 2'b00, 4'b1111, 3'b001, 1'b0, "rw_enter");
        nxt();
        push(2'b00, 2'b00, 4'b1111, 3'b001, 1'b0, "rw_w1");
        nxt();
        push(2'b00, 2'b00, 4'b1111, 3'b001, 1'b0, "rw_w2");
        nxt(); rst_n = 0;
        push(2'b00, 2'b00, 4'b0000, 3'b111, 1'b0, "rst_mid");
        nxt();
        push(2'b00, 2'b00, 4'b0000, 3'b111, 1'b0, "rst_hold");
        nxt(); rst_n = 1; mem_req_m = 0;
        push(2'b00, 2'b00, 4'b0000, 3'b000, 1'b0, "rst_rel_run");
        nxt(); mem_req_m = 1;
        push(2'b00, 2'b00, 4'b1111, 3'b001, 1'b0, "rw2_enter");
        for (int i = 1; i <= 3; i++) begin
            nxt();
            push(2'b00, 2'b00, 4'b1111, 3'b001, 1'b0, $sformatf("rw2_w%0d", i));
        end
        nxt(); mem_ready_m = 1;
        push(2'b00, 2'b00, 4'b0000, 3'b000, 1'b0, "rw2_ready_at_limit");
        nxt(); idle_in();
        push(2'b00, 2'b00, 4'b0000, 3'b000, 1'b0, "rw2_after");
        nxt(); pc_src_e = 1;
        push(2'b00, 2'b00, 4'b0000, 3'b110, 1'b0, "end_branch");
        nxt(); pc_src_e = 0; result_src_e0 = 1; rd_e = 4; rs1_d = 4;
        push(2'b00, 2'b00, 4'b1100, 3'b010, 1'b0, "end_load_use");
        nxt(); idle_in();
        push(2'b00, 2'b00, 4'b0000, 3'b000, 1'b0, "end_idle");

        // Drain the scoreboard with a bounded wait.
        for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge clk);
        if (sb.size() > 0) begin
            fails++;
            $display("FAIL drain: %0d items left, want 0", sb.size());
        end
        @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule
